pair_exit_queue: RTL

- Parametrised successor to the pair-exit FIFO; buffers pair records leaving the force pipeline for host/readback.
- Time-multiplexed input: a free-running frame counter allots SLOT_COUNT write slots per FRAME_LEN-cycle frame; null pairs are filtered.
- Adds an internal RAM-backed queue, latched (not lost) host read requests, a selectable read mode, a registered output with valid strobe, fill level, and a sticky overflow flag.

---
 rtl/pair_exit_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pair_exit_queue.sv
// Pair-exit queue: slot-multiplexed writes of non-null pair records into a RAM-backed FIFO,
// with latched host read requests and a registered payload output.
module pair_exit_queue #(
    parameter int DATA_W     = 192,
    parameter int REC_W      = 227,
    parameter int FLAG_A     = 194,
    parameter int FLAG_B     = 195,
    parameter int SLOT_COUNT = 14,
    parameter int FRAME_LEN  = 16,
    parameter int DEPTH      = 64,
    parameter int READ_MODE  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [REC_W-1:0]             in_data,
    input  logic                         in_valid,
    input  logic                         read_ctrl,
    input  logic                         clr_overflow,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    output logic                         qempty,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic [$clog2(FRAME_LEN)-1:0] slot
);

    localparam int SLOT_W = $clog2(FRAME_LEN);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);
    localparam logic [SLOT_W-1:0] SLOTS_V   = SLOT_W'(SLOT_COUNT);
    localparam logic [LVL_W-1:0]  DEPTH_V   = LVL_W'(DEPTH);
    localparam bit                ANY_CYCLE = (READ_MODE == 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              pending_q, pending_d;
    logic              rd_prev_q, rd_prev_d;
    logic              qempty_q, qempty_d;
    logic              overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic rd_edge, service, pop, eligible, push;

    // Record bits above the payload only matter through the null-pair flags.
    logic unused_rec;
    assign unused_rec = ^in_data;

    always_comb begin
        slot_d      = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        rd_prev_d   = read_ctrl;
        rd_edge     = read_ctrl && !rd_prev_q;
        service     = pending_q && (ANY_CYCLE || (slot_q == LAST_SLOT));
        pop         = service && (level_q != '0);
        eligible    = in_valid && (slot_q < SLOTS_V) && !(in_data[FLAG_A] && in_data[FLAG_B]);
        // A pop in the same cycle frees the slot a full queue would otherwise refuse.
        push        = eligible && ((level_q < DEPTH_V) || pop);

        // An edge landing on the service cycle survives as the next request.
        pending_d   = service ? rd_edge : (pending_q || rd_edge);

        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d     = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        out_valid_d = pop;
        out_data_d  = pop ? mem[rd_ptr_q] : out_data_q;
        qempty_d    = (slot_q == LAST_SLOT) ? (level_q == '0) : qempty_q;

        overflow_d  = overflow_q;
        if (eligible && !push) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q      <= LAST_SLOT;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pending_q   <= 1'b0;
            rd_prev_q   <= 1'b0;
            qempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            slot_q      <= slot_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pending_q   <= pending_d;
            rd_prev_q   <= rd_prev_d;
            qempty_q    <= qempty_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // NOTE: storage has no reset so it maps onto plain RAM; level/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data[DATA_W-1:0];
        end
    end

    assign slot      = slot_q;
    assign level     = level_q;
    assign qempty    = qempty_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
